// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the time-multiplexed button debouncer.
package debounce_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int unsigned DEF_N_BTN         = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 1000;

  function automatic int unsigned idx_width(input int unsigned n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debouncer for N_BTN buttons sharing one stability counter; a round-robin scanner
// hands the counter to the first button whose synchronized level differs from its output.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [N_BTN-1:0]           btn_in,
  output logic [N_BTN-1:0]           db_out,
  output logic [N_BTN-1:0]           press_pulse,
  output logic [N_BTN-1:0]           release_pulse,
  output logic                       busy,
  output logic [$clog2(N_BTN)-1:0]   active_idx
);

  localparam int unsigned      IDX_W    = idx_width(N_BTN);
  localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic [N_BTN-1:0] btn_sync;
  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, owner;
  logic [CNT_W-1:0] cnt;
  logic             scan_hit, own_bounce, own_done;

  for (genvar i = 0; i < N_BTN; i++) begin : g_sync
    sync_2ff #(.RESET_VAL(INIT_LEVEL)) u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .d       (btn_in[i]),
      .q       (btn_sync[i])
    );
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign scan_hit   = btn_sync[ptr] != db_out[ptr];
  assign own_bounce = btn_sync[owner] == db_out[owner];
  assign own_done   = cnt == LAST_CNT;

  always_ff @(posedge clk) begin
    if (!n_reset) state <= SCAN;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:  if (scan_hit)               state_nxt = TRACK;
      TRACK: if (own_bounce || own_done) state_nxt = SCAN;
      default:                           state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ptr           <= '0;
      owner         <= '0;
      cnt           <= '0;
      db_out        <= {N_BTN{INIT_LEVEL}};
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      case (state)
        SCAN: begin
          if (scan_hit) begin
            owner <= ptr;
            cnt   <= '0;
          end else begin
            ptr <= next_idx(ptr);
          end
        end
        TRACK: begin
          if (own_bounce) begin
            ptr <= next_idx(owner);
          end else if (own_done) begin
            // Commit: the old output level selects which edge pulse fires.
            db_out[owner] <= ~db_out[owner];
            if (db_out[owner]) release_pulse[owner] <= 1'b1;
            else               press_pulse[owner]   <= 1'b1;
            ptr <= next_idx(owner);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ptr <= '0;
      endcase
    end
  end

  always_comb begin
    busy       = (state == TRACK);
    active_idx = (state == TRACK) ? owner : ptr;
  end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Shared-engine debouncer for the board's push buttons. One stability counter is time-multiplexed across `N_BTN` raw button inputs by a round-robin scanner, so adding buttons costs a flop per button rather than a counter per button. Outputs are clean per-button levels plus one-cycle press/release pulses. It sits between the pad inputs and the LCD/SPI control logic.

## Interface
- `N_BTN`, default 4: number of buttons; must be ≥ 2.
- `STABLE_CYCLES`, default 1000: consecutive cycles a changed level must hold before it is accepted; must be ≥ 2.
- `INIT_LEVEL`, default 1'b0: reset value of synchronizers and `db_out`; the released level.
- `clk`  in  1: system clock.
- `n_reset`  in  1: reset, synchronous, active-low.
- `btn_in`  in  N_BTN: raw asynchronous button levels.
- `db_out`  out  N_BTN: debounced levels.
- `press_pulse`  out  N_BTN: one-cycle pulse on a `db_out` transition 0→1.
- `release_pulse`  out  N_BTN: one-cycle pulse on a `db_out` transition 1→0.
- `busy`  out  1: high while the engine is in TRACK.
- `active_idx`  out  $clog2(N_BTN): scan pointer in SCAN, owning button in TRACK.

## Operation
- Each `btn_in` bit goes through a 2-flop synchronizer to form `btn_sync`. Everything below uses `btn_sync`.
- FSM has two states, SCAN and TRACK. Registers:
  - `ptr`: scan pointer.
  - `owner`: button currently holding the engine.
  - `cnt`: width $clog2(STABLE_CYCLES).
- SCAN:
  - If `btn_sync[ptr] != db_out[ptr]`: `owner<=ptr`, `cnt<=0`, go to TRACK.
  - Otherwise `ptr<=ptr+1`, wrapping from N_BTN-1 to 0.
- TRACK:
  - If `btn_sync[owner] == db_out[owner]`: abort (bounce). `ptr<=owner+1` (wrapped), go to SCAN. No output change.
  - Else if `cnt == STABLE_CYCLES-1`: commit.
    - `db_out[owner]` toggles.
    - The matching press or release pulse goes high for the next cycle only.
    - `ptr<=owner+1` (wrapped), go to SCAN.
  - Else `cnt<=cnt+1`.
- Only the owner is tracked. Other buttons are sampled only when the scanner reaches them. A change that reverts before it is scanned is ignored by design.
- At most one `db_out` bit changes per cycle. At most one pulse bit is high per cycle.
- Reset (`n_reset`=0 at a clock edge):
  - `db_out` and synchronizers = INIT_LEVEL.
  - Pulses = 0, `busy` = 0, `active_idx` = 0.
  - `ptr`, `owner`, `cnt` = 0; state = SCAN.
  - A reset during TRACK discards the track with no pulse.

## Timing
- Synchronizer latency is 2 cycles.
- A button already pointed to in SCAN enters TRACK 1 cycle after its `btn_sync` differs.
- Time in TRACK before commit is exactly STABLE_CYCLES cycles. `db_out` and the pulse update on the following edge.
- Best-case latency from a `btn_in` edge to the `db_out` change: 2 + 1 + STABLE_CYCLES cycles.
- Extra worst-case wait for a scanned button: (N_BTN-1)·(STABLE_CYCLES+1) cycles, when every other button is tracked first.
- Pulses are registered and last exactly 1 cycle. `busy` is registered and equals (state==TRACK).
- Abort takes effect on the first cycle `btn_sync[owner]` matches `db_out[owner]`; the next cycle is SCAN at owner+1.
- Simultaneous changes are served in round-robin order starting from `ptr`.

## Structure
- Package `debounce_pkg`:
  - `state_t` enum {SCAN, TRACK}.
  - Width helper constants derived via $clog2.
- Sub-module `sync_2ff`, instantiated per bit. It has a synchronous active-low reset and a reset-value parameter.
- Scanner, counter and output registers live in `debounce_scheduler`.

## Test plan
Bench: 20 ns clock, `N_BTN`=4, `STABLE_CYCLES`=16, `INIT_LEVEL`=0.
- Clean press: `btn_in[0]` goes 0→1 and holds. `db_out[0]` rises after ≤ 2+1+16+3 cycles. `press_pulse[0]` is high exactly 1 cycle. No other outputs change.
- Bounce: `btn_in[1]` toggles every 5 cycles for 40 cycles, then holds 1. No `db_out[1]` change during the bounce. Exactly one `press_pulse[1]`, ≥16 cycles after the final edge.
- Simultaneous: `btn_in[2]` and `btn_in[3]` rise on the same cycle with `ptr`=0. `db_out[2]` commits first, `db_out[3]` ≥17 cycles later, one pulse each.
- Release: after the clean press, `btn_in[0]` goes 1→0 and holds. `release_pulse[0]` is high 1 cycle and `db_out[0]`=0.
- Reset mid-track: assert `n_reset`=0 when `busy`=1 and `cnt`≈8. All outputs reach their reset values on the next edge with no pulse. After release, a held level is re-debounced from scratch.
